// File: rtl/modn_counter_pkg.sv
// modn_counter_pkg: FSM state type and count-direction constants shared by
// modn_counter and modn_step.
package modn_counter_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam logic CNT_UP = 1'b1;
   localparam logic CNT_DN = 1'b0;
endpackage

// File: rtl/modn_step.sv
// modn_step: combinational modulo-N next value and wrap detection for one count step.
module modn_step
   import modn_counter_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 5
) (
   input  logic [WIDTH-1:0] count_i,
   input  logic             up_dn_i,
   output logic [WIDTH-1:0] next_o,
   output logic             is_wrap_o
);
   localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
   always_comb begin
      is_wrap_o = (up_dn_i == CNT_UP) ? (count_i == MAX) : (count_i == '0);
      next_o    = is_wrap_o ? ((up_dn_i == CNT_UP) ? '0 : MAX)
                            : ((up_dn_i == CNT_UP) ? count_i + 1'b1 : count_i - 1'b1);
   end
endmodule

// File: rtl/modn_counter.sv
// modn_counter: modulo-N up/down counter with IDLE/RUN/DONE control FSM.
// Define MODN_COUNTER_WRAPCNT_EN to add the saturating wrap_cnt output.
module modn_counter
   import modn_counter_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 5,
   parameter int WRAP_W  = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              stop,
   input  logic              en,
   input  logic              up_dn,
   input  logic              mode,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_val,
   output logic [WIDTH-1:0]  count,
   output logic              tc,
   output logic              wrap,
   output logic              busy,
`ifdef MODN_COUNTER_WRAPCNT_EN
   output logic [WRAP_W-1:0] wrap_cnt,
`endif
   output logic              done
);
   localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

   if (MODULUS < 2 || MODULUS > (1 << WIDTH) || WRAP_W < 1) begin : g_bad_params
      $error("modn_counter: need 2 <= MODULUS <= 2**WIDTH and WRAP_W >= 1");
   end

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d, step_next;
   logic             wrap_q, wrap_d, term, do_start, do_adv;

   modn_step #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_step (
      .count_i  (count_q),
      .up_dn_i  (up_dn),
      .next_o   (step_next),
      .is_wrap_o(term)
   );

   // load beats stop beats start beats advance; start while running falls through to advance
   assign do_start = !load && !stop && start && state_q != RUN;
   assign do_adv   = !load && !stop && state_q == RUN && en;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         count_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         wrap_q  <= wrap_d;
      end
   end

   always_comb begin
      state_d = load ? state_q : stop ? IDLE : do_start ? RUN : (do_adv && mode && term) ? DONE : state_q;
      count_d = load ? ((int'(load_val) >= MODULUS) ? MAX : load_val)
              : (do_start && state_q == DONE) ? ((up_dn == CNT_DN) ? MAX : '0)
              : (do_adv && !(mode && term)) ? step_next
              : count_q;
      wrap_d  = do_adv && !mode && term;
   end

   always_comb begin
      busy = state_q == RUN;
      done = state_q == DONE;
   end

   assign count = count_q;
   assign tc    = term;
   assign wrap  = wrap_q;

`ifdef MODN_COUNTER_WRAPCNT_EN
   logic [WRAP_W-1:0] wrap_cnt_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) wrap_cnt_q <= '0;
      else if (load) wrap_cnt_q <= '0;
      else if (wrap_d && !(&wrap_cnt_q)) wrap_cnt_q <= wrap_cnt_q + 1'b1;
   end
   assign wrap_cnt = wrap_cnt_q;
`endif
endmodule
